// File: rtl/pipe_reg_elastic.sv
// Elastic pipeline-stage register with optional 2-entry skid buffer.
// Control field is gated to zero whenever the head entry is a bubble.
module pipe_reg_elastic #(
  parameter int WIDTH  = 96,
  parameter int CTRL_W = 8,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0]  main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              rdy_q;
  logic              it, ot;
  logic              load_main_in;
  logic              load_main_skid;
  logic              load_skid;

  assign out_valid = (state != EMPTY);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl & {CTRL_W{out_valid}};

  // Skid mode: ready is a flop, no path from out_ready.
  assign in_ready = (SKID != 0) ? rdy_q
                                : (~out_valid | out_ready);

  assign it = in_valid & in_ready;
  assign ot = out_valid & out_ready;

  always_comb begin
    state_nx       = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nx = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (it) begin
            state_nx     = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (it && ot) begin
            load_main_in = 1'b1;
          end else if (it) begin
            if (SKID != 0) begin
              state_nx  = FULL;
              load_skid = 1'b1;
            end else begin
              load_main_in = 1'b1;
            end
          end else if (ot) begin
            state_nx = EMPTY;
          end
        end
        FULL: begin
          if (ot) begin
            state_nx       = ONE;
            load_main_skid = 1'b1;
          end
        end
        default: state_nx = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      rdy_q     <= 1'b1;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      state <= state_nx;
      rdy_q <= (state_nx != FULL);
      if (load_main_in) begin
        main_data <= in_data;
        main_ctrl <= in_ctrl;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_ctrl <= in_ctrl;
      end
    end
  end

endmodule

// File: tb/tb_pipe_reg_elastic.sv
// Bench for pipe_reg_elastic: queue model for SKID=1 plus
// directed literal checks for both SKID=1 and SKID=0.
module tb_pipe_reg_elastic;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [95:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [95:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;

  logic        b_flush;
  logic        b_in_valid;
  logic        b_in_ready;
  logic [95:0] b_in_data;
  logic [7:0]  b_in_ctrl;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [95:0] b_out_data;
  logic [7:0]  b_out_ctrl;
  logic [1:0]  b_occupancy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  pipe_reg_elastic #(.WIDTH(96), .CTRL_W(8), .SKID(1)) u_dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy)
  );

  pipe_reg_elastic #(.WIDTH(96), .CTRL_W(8), .SKID(0)) u_dut0 (
    .clk(clk), .rst(rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ctrl(b_in_ctrl),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ctrl(b_out_ctrl),
    .occupancy(b_occupancy)
  );

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // Model: in-order queue, capacity 2, ready known one cycle late.
  typedef struct {
    logic [95:0] d;
    logic [7:0]  c;
  } ent_t;

  ent_t        q[$];
  logic [95:0] rx[$];
  bit          m_rdy  = 1'b1;
  bit          m_init = 1'b0;
  bit          m_it, m_ot;

  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_rdy  = 1'b1;
      m_init = 1'b1;
    end else begin
      m_it = in_valid && m_rdy;
      m_ot = (q.size() != 0) && out_ready;
      if (flush) begin
        q.delete();
      end else begin
        if (m_ot) void'(q.pop_front());
        if (m_it) q.push_back('{in_data, in_ctrl});
      end
      m_rdy = (q.size() != 2);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("occupancy", 128'(occupancy), 128'(q.size()));
      chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
      chk("in_ready", 128'(in_ready), 128'(m_rdy));
      chk("out_ctrl", 128'(out_ctrl),
          (q.size() != 0) ? 128'(q[0].c) : 128'(0));
      if (q.size() != 0)
        chk("out_data", 128'(out_data), 128'(q[0].d));
      if (out_valid && out_ready)
        rx.push_back(out_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst         = 1'b1;
    flush       = 1'b0;
    in_valid    = 1'b1;
    in_data     = 96'hA5;
    in_ctrl     = 8'h3C;
    out_ready   = 1'b1;
    b_flush     = 1'b0;
    b_in_valid  = 1'b0;
    b_in_data   = '0;
    b_in_ctrl   = '0;
    b_out_ready = 1'b0;

    // reset held 2 cycles with a pending entry
    step();
    step();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    chk("rst_out_ctrl", 128'(out_ctrl), 128'(0));
    chk("rst_occupancy", 128'(occupancy), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_b_in_ready", 128'(b_in_ready), 128'(1));
    chk("rst_b_out_valid", 128'(b_out_valid), 128'(0));

    rst = 1'b0;
    step();
    chk("first_valid", 128'(out_valid), 128'(1));
    chk("first_data", 128'(out_data), 128'hA5);
    chk("first_ctrl", 128'(out_ctrl), 128'h3C);
    in_valid = 1'b0;
    step();
    chk("first_drain", 128'(out_valid), 128'(0));

    // streaming 1..8
    rx.delete();
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1;
      in_data  = 96'(i);
      in_ctrl  = 8'(i);
      step();
      chk("stream_data", 128'(out_data), 128'(i));
      chk("stream_occ", 128'(occupancy), 128'(1));
    end
    in_valid = 1'b0;
    step();
    chk("stream_count", 128'(rx.size()), 128'(8));
    for (int i = 0; i < 8 && i < rx.size(); i++)
      chk("stream_order", 128'(rx[i]), 128'(i + 1));

    // backpressure
    rx.delete();
    in_valid = 1'b1;
    in_data  = 96'h10;
    step();
    in_data   = 96'h11;
    out_ready = 1'b0;
    step();
    chk("bp_occ_full", 128'(occupancy), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_head", 128'(out_data), 128'h10);
    in_data = 96'h12;
    step();
    step();
    chk("bp_hold_occ", 128'(occupancy), 128'(2));
    chk("bp_hold_head", 128'(out_data), 128'h10);
    out_ready = 1'b1;
    step();
    chk("bp_drain1", 128'(out_data), 128'h11);
    step();
    chk("bp_drain2", 128'(out_data), 128'h12);
    in_valid = 1'b0;
    step();
    chk("bp_count", 128'(rx.size()), 128'(3));
    for (int i = 0; i < 3 && i < rx.size(); i++)
      chk("bp_order", 128'(rx[i]), 128'(16 + i));

    // bubble gating of ctrl
    in_valid = 1'b1;
    in_data  = 96'h77;
    in_ctrl  = 8'hFF;
    step();
    chk("bubble_ctrl_on", 128'(out_ctrl), 128'hFF);
    in_valid = 1'b0;
    step();
    chk("bubble_ctrl_off", 128'(out_ctrl), 128'h00);
    chk("bubble_valid", 128'(out_valid), 128'(0));

    // flush while full with an incoming entry
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_ctrl   = 8'h5A;
    in_data   = 96'h20;
    step();
    in_data = 96'h21;
    step();
    chk("fl_full", 128'(occupancy), 128'(2));
    rx.delete();
    in_data = 96'h99;
    flush   = 1'b1;
    step();
    chk("fl_occ", 128'(occupancy), 128'(0));
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_ctrl", 128'(out_ctrl), 128'(0));
    flush     = 1'b0;
    out_ready = 1'b1;
    in_data   = 96'h30;
    step();
    chk("fl_next", 128'(out_data), 128'h30);
    in_valid = 1'b0;
    step();
    chk("fl_rx_count", 128'(rx.size()), 128'(1));
    if (rx.size() != 0)
      chk("fl_rx_data", 128'(rx[0]), 128'h30);

    // SKID=0: combinational ready
    b_in_valid  = 1'b1;
    b_in_data   = 96'h40;
    b_in_ctrl   = 8'h81;
    b_out_ready = 1'b0;
    step();
    chk("s0_valid", 128'(b_out_valid), 128'(1));
    chk("s0_data", 128'(b_out_data), 128'h40);
    chk("s0_occ", 128'(b_occupancy), 128'(1));
    chk("s0_rdy_low", 128'(b_in_ready), 128'(0));
    b_in_data = 96'h41;
    step();
    chk("s0_hold", 128'(b_out_data), 128'h40);
    b_out_ready = 1'b1;
    #1;
    chk("s0_rdy_high", 128'(b_in_ready), 128'(1));
    step();
    chk("s0_replace", 128'(b_out_data), 128'h41);
    chk("s0_occ1", 128'(b_occupancy), 128'(1));
    b_in_valid = 1'b0;
    step();
    chk("s0_empty", 128'(b_out_valid), 128'(0));
    chk("s0_ctrl0", 128'(b_out_ctrl), 128'(0));
    chk("s0_occ0", 128'(b_occupancy), 128'(0));

    step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
